// File: rtl/ssd_pkg.sv
// Shared constants and types for the active-low 7-segment readers.
package ssd_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low segment codes for digits 0..9 (bit0=a .. bit5=f, bit6=g).
  localparam logic [6:0] SEG_TABLE [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  typedef enum logic {ACQUIRE, LOCKED} ssd_rd_state_t;

  typedef enum logic [1:0] {SEG_DIGIT, SEG_BLANK_C, SEG_ILLEGAL} seg_class_t;

endpackage

// File: rtl/ssd_pattern_decode.sv
// Combinational classifier: active-low segment pattern -> digit / blank / illegal.
module ssd_pattern_decode
  import ssd_pkg::*;
(
  input  logic [6:0] seg_n,
  output seg_class_t seg_class,
  output logic [3:0] digit
);

  // Table lookup; anything that is neither a digit nor all-off is illegal.
  always_comb begin
    seg_class = SEG_ILLEGAL;
    digit     = 4'd0;
    if (seg_n == SEG_BLANK) begin
      seg_class = SEG_BLANK_C;
    end
    for (int i = 0; i < 10; i++) begin
      if (seg_n == SEG_TABLE[i]) begin
        seg_class = SEG_DIGIT;
        digit     = 4'(i);
      end
    end
  end

endmodule

// File: rtl/ssd_reader.sv
// Display monitor: recovers the BCD digit from an active-low 7-segment bus,
// committing a pattern only after it has held for STABLE_CYCLES samples.
//
// state   | meaning
// --------+----------------------------------------------------------------
// ACQUIRE | waiting for the sampled pattern to hold; outputs keep last commit
// LOCKED  | current pattern committed; waiting for the bus to change
module ssd_reader
  import ssd_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] seg_n,
  output logic [3:0] digit,
  output logic       digit_valid,
  output logic       digit_strobe,
  output logic       blank,
  output logic       illegal,
  output logic [7:0] glitch_cnt
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  ssd_rd_state_t state_q, state_d;
  logic [6:0]    seg_q, seg_d;
  logic [6:0]    seg_p_q, seg_p_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          first_q, first_d;
  logic [3:0]    digit_q, digit_d;
  logic          valid_q, valid_d;
  logic          strobe_q, strobe_d;
  logic          blank_q, blank_d;
  logic          illegal_q, illegal_d;
  logic [7:0]    glitch_q, glitch_d;

  logic          changed;
  logic          commit;
  seg_class_t    dec_class;
  logic [3:0]    dec_digit;

  // cnt_q is the run length of seg_p_q, so the committed pattern is seg_p_q.
  ssd_pattern_decode u_decode (
    .seg_n     (seg_p_q),
    .seg_class (dec_class),
    .digit     (dec_digit)
  );

  // Next-state, stability counting, glitch accounting and commit.
  always_comb begin
    state_d   = state_q;
    seg_d     = seg_n;
    seg_p_d   = seg_q;
    cnt_d     = cnt_q;
    first_d   = first_q;
    digit_d   = digit_q;
    valid_d   = valid_q;
    strobe_d  = 1'b0;
    blank_d   = blank_q;
    illegal_d = illegal_q;
    glitch_d  = glitch_q;
    commit    = 1'b0;

    changed = (seg_q != seg_p_q);

    if (changed) begin
      cnt_d   = CW'(1);
      first_d = 1'b0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end

    case (state_q)
      ACQUIRE: begin
        if (cnt_q == CNT_MAX) begin
          commit = 1'b1;
          // A pattern that just made it is still committed; the new one restarts acquisition.
          if (!changed) state_d = LOCKED;
        end else if (changed && cnt_q != '0 && !first_q && glitch_q != 8'hFF) begin
          glitch_d = glitch_q + 8'd1;
        end
      end
      LOCKED: begin
        if (changed) state_d = ACQUIRE;
      end
      default: state_d = ACQUIRE;
    endcase

    if (commit) begin
      case (dec_class)
        SEG_DIGIT: begin
          strobe_d  = !valid_q || (dec_digit != digit_q);
          digit_d   = dec_digit;
          valid_d   = 1'b1;
          blank_d   = 1'b0;
          illegal_d = 1'b0;
        end
        SEG_BLANK_C: begin
          valid_d   = 1'b0;
          blank_d   = 1'b1;
          illegal_d = 1'b0;
        end
        default: begin
          valid_d   = 1'b0;
          blank_d   = 1'b0;
          illegal_d = 1'b1;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ACQUIRE;
      seg_q     <= SEG_BLANK;
      seg_p_q   <= SEG_BLANK;
      cnt_q     <= '0;
      first_q   <= 1'b1;
      digit_q   <= 4'd0;
      valid_q   <= 1'b0;
      strobe_q  <= 1'b0;
      blank_q   <= 1'b0;
      illegal_q <= 1'b0;
      glitch_q  <= 8'd0;
    end else begin
      state_q   <= state_d;
      seg_q     <= seg_d;
      seg_p_q   <= seg_p_d;
      cnt_q     <= cnt_d;
      first_q   <= first_d;
      digit_q   <= digit_d;
      valid_q   <= valid_d;
      strobe_q  <= strobe_d;
      blank_q   <= blank_d;
      illegal_q <= illegal_d;
      glitch_q  <= glitch_d;
    end
  end

  assign digit        = digit_q;
  assign digit_valid  = valid_q;
  assign digit_strobe = strobe_q;
  assign blank        = blank_q;
  assign illegal      = illegal_q;
  assign glitch_cnt   = glitch_q;

endmodule

// File: tb/tb_ssd_reader.sv
// Scoreboard bench for ssd_reader: two instances (STABLE_CYCLES 4 and 1) share
// one stimulus stream; a run-length reference model predicts every cycle.
module tb_ssd_reader;

  typedef struct packed {
    logic [3:0] digit;
    logic       valid;
    logic       strobe;
    logic       blank;
    logic       illegal;
    logic [7:0] glitch;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] seg_n = 7'h7F;

  logic [3:0] digit4, digit1;
  logic       valid4, valid1, strobe4, strobe1, blank4, blank1, illegal4, illegal1;
  logic [7:0] glitch4, glitch1;

  always #5 clk = ~clk;

  ssd_reader #(.STABLE_CYCLES(4)) dut4 (
    .clk(clk), .reset(reset), .seg_n(seg_n),
    .digit(digit4), .digit_valid(valid4), .digit_strobe(strobe4),
    .blank(blank4), .illegal(illegal4), .glitch_cnt(glitch4)
  );

  ssd_reader #(.STABLE_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .seg_n(seg_n),
    .digit(digit1), .digit_valid(valid1), .digit_strobe(strobe1),
    .blank(blank1), .illegal(illegal1), .glitch_cnt(glitch1)
  );

  obs_t       exp_q4[$];
  obs_t       exp_q1[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;

  // Sampled pattern after each edge since the last reset edge (index 0 = reset value).
  logic [6:0] hist[$];
  int         sval[2] = '{4, 1};
  logic [3:0] m_digit[2];
  logic       m_valid[2];
  logic       m_blank[2];
  logic       m_illegal[2];
  logic [7:0] m_glitch[2];
  logic [6:0] tab[10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                          7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  // 0..9 digit, 10 blank, 11 illegal
  function automatic int classify(input logic [6:0] p);
    int c = 11;
    if (p == 7'h7F) c = 10;
    for (int k = 0; k < 10; k++) if (tab[k] == p) c = k;
    return c;
  endfunction

  // Length of the run of equal samples ending at idx (capped).
  function automatic int run_len(input int idx);
    int n = 1;
    while (idx - n >= 0 && n < 16 && hist[idx - n] == hist[idx]) n++;
    return n;
  endfunction

  // Expected outputs after the upcoming edge with inputs (r, x).
  task automatic model_edge(input logic r, input logic [6:0] x);
    obs_t e;
    int   j, len, c;
    logic stb;
    if (r) begin
      hist.delete();
      hist.push_back(7'h7F);
    end else begin
      hist.push_back(x);
    end
    j = hist.size() - 1;
    for (int i = 0; i < 2; i++) begin
      stb = 1'b0;
      if (r) begin
        m_digit[i] = 4'd0; m_valid[i] = 1'b0; m_blank[i] = 1'b0;
        m_illegal[i] = 1'b0; m_glitch[i] = 8'd0;
      end else if (j >= 2) begin
        len = run_len(j - 2);
        // A run shorter than the threshold ended: glitch, unless it is the post-reset run.
        if (hist[j-1] != hist[j-2] && len < sval[i] && len != j - 1 && m_glitch[i] != 8'd255)
          m_glitch[i] = m_glitch[i] + 8'd1;
        // A run that has just reached the threshold gets committed.
        if (len == sval[i]) begin
          c = classify(hist[j-2]);
          if (c < 10) begin
            stb = !m_valid[i] || (m_digit[i] != 4'(c));
            m_digit[i] = 4'(c); m_valid[i] = 1'b1; m_blank[i] = 1'b0; m_illegal[i] = 1'b0;
          end else if (c == 10) begin
            m_valid[i] = 1'b0; m_blank[i] = 1'b1; m_illegal[i] = 1'b0;
          end else begin
            m_valid[i] = 1'b0; m_blank[i] = 1'b0; m_illegal[i] = 1'b1;
          end
        end
      end
      e = '{digit: m_digit[i], valid: m_valid[i], strobe: stb, blank: m_blank[i],
            illegal: m_illegal[i], glitch: m_glitch[i]};
      if (i == 0) exp_q4.push_back(e);
      else        exp_q1.push_back(e);
    end
  endtask

  task automatic step(input logic r, input logic [6:0] x);
    @(negedge clk);
    reset = r;
    seg_n = x;
    cyc++;
    model_edge(r, x);
  endtask

  task automatic hold(input logic [6:0] x, input int n);
    for (int i = 0; i < n; i++) step(1'b0, x);
  endtask

  task automatic check(input string name, input obs_t act, input obs_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got dig=%0d v=%b s=%b b=%b i=%b g=%0d, expected dig=%0d v=%b s=%b b=%b i=%b g=%0d",
               name, cyc, act.digit, act.valid, act.strobe, act.blank, act.illegal, act.glitch,
               exp.digit, exp.valid, exp.strobe, exp.blank, exp.illegal, exp.glitch);
    end
  endtask

  // Monitor: compare each DUT's outputs against the queued prediction after every edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q4.size() > 0)
        check("stable4", {digit4, valid4, strobe4, blank4, illegal4, glitch4}, exp_q4.pop_front());
      if (exp_q1.size() > 0)
        check("stable1", {digit1, valid1, strobe1, blank1, illegal1, glitch1}, exp_q1.pop_front());
    end
  end

  initial begin
    logic [6:0] p;
    int         sel;
    // Reset, then 0 held: commit visible 6 edges after release.
    step(1'b1, 7'h40);
    step(1'b1, 7'h40);
    hold(7'h40, 12);
    // Digit steps 1 then 2, then lock on 3.
    hold(7'h79, 10);
    hold(7'h24, 10);
    hold(7'h30, 10);
    // Short excursion to 4 and back: no strobe, one glitch.
    hold(7'h19, 2);
    hold(7'h30, 10);
    // Blank then illegal.
    hold(7'h7F, 10);
    hold(7'h55, 10);
    // Alternating single-cycle patterns saturate the glitch counter.
    for (int i = 0; i < 300; i++) step(1'b0, (i % 2 == 0) ? 7'h40 : 7'h79);
    hold(7'h79, 10);
    // Reset in the middle of an acquisition.
    hold(7'h12, 2);
    step(1'b1, 7'h12);
    hold(7'h12, 8);
    // Post-reset blank hold, then a change (first change is not a glitch).
    step(1'b1, 7'h7F);
    hold(7'h7F, 2);
    hold(7'h24, 8);
    // Random segments with random hold lengths and occasional resets.
    for (int s = 0; s < 250; s++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 6)      p = tab[$urandom_range(0, 9)];
      else if (sel == 7) p = 7'h7F;
      else               p = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 39) == 0) step(1'b1, p);
      hold(p, $urandom_range(1, 7));
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_q4.size() != 0 || exp_q1.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d/%0d predictions left, expected 0/0", exp_q4.size(), exp_q1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
